// File: rtl/alu_exec_unit.sv
// Integer execute unit: RV32/64-style ALU ops in one cycle, MUL/DIVU/REMU iteratively.
// Latency: single-cycle ops valid the cycle after accept; MUL/DIVU/REMU valid XLEN+1 cycles after accept.
// Backpressure: result held until out_ready; in_ready only while idle, requests seen while busy are dropped.
//
// Ports: clk, reset (sync, active-high); in_valid/in_ready request handshake with aluop, funct3,
// funct7, op_a, op_b; out_valid/out_ready result handshake with result, zero (result == 0) and
// illegal (undecodable encoding, result forced to 0).
module alu_exec_unit #(
  parameter int XLEN     = 32,
  parameter int ENABLE_M = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      aluop,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam int SW = $clog2(XLEN);
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
  typedef enum logic [1:0] {IT_MUL, IT_DIV, IT_REM} iter_t;

  state_t          state, state_nxt;
  iter_t           kind, dec_kind;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] result_q;
  logic            illegal_q;

  // Iteration registers. MUL: acc = partial sum, opx = shifted multiplicand, sh = multiplier.
  // DIVU/REMU: acc = partial remainder, opx = divisor, sh = dividend shifting out / quotient shifting in.
  logic [XLEN-1:0] acc, opx, sh;
  logic [XLEN-1:0] acc_nxt, opx_nxt, sh_nxt;
  logic [XLEN:0]   r_shift;
  logic            r_ge;

  logic [XLEN-1:0] dec_res;
  logic            dec_ill;
  logic            dec_iter;

  function automatic logic [XLEN-1:0] alu_base(input logic [2:0] f3, input logic alt,
                                               input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    r = '0;
    case (f3)
      3'b000: r = a + b;
      3'b001: r = a << b[SW-1:0];
      3'b010: r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      3'b011: r = {{(XLEN-1){1'b0}}, (a < b)};
      3'b100: r = a ^ b;
      3'b101: r = alt ? XLEN'($signed(a) >>> b[SW-1:0]) : (a >> b[SW-1:0]);
      3'b110: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  // Decode of the request as presented; only consumed on the accept cycle.
  always_comb begin
    dec_res  = '0;
    dec_ill  = 1'b0;
    dec_iter = 1'b0;
    dec_kind = IT_MUL;
    case (aluop)
      2'b00: dec_res = alu_base(funct3, funct7[5], op_a, op_b);
      2'b01: dec_res = op_a - op_b;
      2'b10: begin
        case (funct7)
          7'b0000000: dec_res = alu_base(funct3, 1'b0, op_a, op_b);
          7'b0100000: begin
            if (funct3 == 3'b000)      dec_res = op_a - op_b;
            else if (funct3 == 3'b101) dec_res = alu_base(3'b101, 1'b1, op_a, op_b);
            else                       dec_ill = 1'b1;
          end
          7'b0000001: begin
            if (ENABLE_M != 0) begin
              case (funct3)
                3'b000:  begin dec_iter = 1'b1; dec_kind = IT_MUL; end
                3'b101:  begin dec_iter = 1'b1; dec_kind = IT_DIV; end
                3'b111:  begin dec_iter = 1'b1; dec_kind = IT_REM; end
                default: dec_ill = 1'b1;
              endcase
            end else begin
              dec_ill = 1'b1;
            end
          end
          default: dec_ill = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
  end

  // One iteration step. The division subtract is done modulo 2^XLEN: when r_ge holds the true
  // difference is below the divisor, and with a zero divisor it degenerates to shifting the
  // dividend into the remainder, which yields all-ones quotient and remainder = dividend.
  always_comb begin
    acc_nxt = acc;
    opx_nxt = opx;
    sh_nxt  = sh;
    r_shift = {acc, sh[XLEN-1]};
    r_ge    = (r_shift >= {1'b0, opx});
    if (kind == IT_MUL) begin
      if (sh[0]) acc_nxt = acc + opx;
      opx_nxt = opx << 1;
      sh_nxt  = sh >> 1;
    end else begin
      sh_nxt  = {sh[XLEN-2:0], r_ge};
      acc_nxt = r_ge ? (r_shift[XLEN-1:0] - opx) : r_shift[XLEN-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = dec_iter ? ITER : DONE;
      end
      ITER: begin
        if (cnt == CNT_LAST) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
      acc       <= '0;
      opx       <= '0;
      sh        <= '0;
      kind      <= IT_MUL;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (dec_iter) begin
              kind <= dec_kind;
              cnt  <= '0;
              acc  <= '0;
              opx  <= (dec_kind == IT_MUL) ? op_a : op_b;
              sh   <= (dec_kind == IT_MUL) ? op_b : op_a;
            end else begin
              result_q  <= dec_res;
              illegal_q <= dec_ill;
            end
          end
        end
        ITER: begin
          acc <= acc_nxt;
          opx <= opx_nxt;
          sh  <= sh_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            cnt       <= '0;
            result_q  <= (kind == IT_DIV) ? sh_nxt : acc_nxt;
            illegal_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign result  = result_q;
  assign illegal = illegal_q;
  assign zero    = (result_q == '0);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed operations checked against literals and a transaction model.
// Latency: model tracks accept-to-valid latency per operation class.
// Backpressure: exercises stalled results, requests while busy, and reset aborts.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_valid0, out_ready;
  logic [1:0]  aluop;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] op_a, op_b;
  logic        in_ready, out_valid, zero, illegal;
  logic [31:0] result;
  logic        in_ready0, out_valid0, zero0, illegal0;
  logic [31:0] result0;

  always #5 clk = ~clk;

  alu_exec_unit #(.XLEN(32), .ENABLE_M(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .aluop(aluop), .funct3(funct3), .funct7(funct7), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero), .illegal(illegal)
  );

  alu_exec_unit #(.XLEN(32), .ENABLE_M(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid0), .in_ready(in_ready0),
    .aluop(aluop), .funct3(funct3), .funct7(funct7), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid0), .out_ready(1'b1), .result(result0), .zero(zero0), .illegal(illegal0)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  // Architectural result of one operation, straight from the instruction semantics.
  function automatic void model_op(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                   input logic [31:0] a, input logic [31:0] b, input bit en_m,
                                   output logic [31:0] r, output bit ill, output int lat);
    logic [63:0] prod;
    int sh;
    sh   = int'(b[4:0]);
    r    = 32'd0;
    ill  = 1'b0;
    lat  = 1;
    prod = 64'd0;
    if (op == 2'b01) begin
      r = a - b;
    end else if (op == 2'b00 || (op == 2'b10 && f7 == 7'h00)) begin
      case (f3)
        3'd0: r = a + b;
        3'd1: r = a << sh;
        3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        3'd3: r = (a < b) ? 32'd1 : 32'd0;
        3'd4: r = a ^ b;
        3'd5: r = (op == 2'b00 && f7[5]) ? 32'($signed(a) >>> sh) : (a >> sh);
        3'd6: r = a | b;
        default: r = a & b;
      endcase
    end else if (op == 2'b10 && f7 == 7'h20 && f3 == 3'd0) begin
      r = a - b;
    end else if (op == 2'b10 && f7 == 7'h20 && f3 == 3'd5) begin
      r = 32'($signed(a) >>> sh);
    end else if (op == 2'b10 && f7 == 7'h01 && en_m && (f3 == 3'd0 || f3 == 3'd5 || f3 == 3'd7)) begin
      lat = 33;
      if (f3 == 3'd0) begin
        prod = {32'd0, a} * {32'd0, b};
        r = prod[31:0];
      end else if (f3 == 3'd5) begin
        r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      end else begin
        r = (b == 0) ? a : a % b;
      end
    end else begin
      ill = 1'b1;
    end
  endfunction

  // Transaction model of the full-featured instance.
  logic        m_valid = 1'b0;
  int          m_wait = 0;
  logic [31:0] m_res = 32'd0;
  bit          m_ill = 1'b0;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin : model
    logic [31:0] r;
    bit ill;
    int lat;
    if (reset) begin
      m_valid <= 1'b0;
      m_wait  <= 0;
      m_res   <= 32'd0;
      m_ill   <= 1'b0;
      chk_en  <= 1'b1;
    end else if (m_wait > 0) begin
      if (m_wait == 1) m_valid <= 1'b1;
      m_wait <= m_wait - 1;
    end else if (m_valid) begin
      if (out_ready) m_valid <= 1'b0;
    end else if (in_valid) begin
      model_op(aluop, funct3, funct7, op_a, op_b, 1'b1, r, ill, lat);
      m_res <= r;
      m_ill <= ill;
      if (lat == 1) m_valid <= 1'b1;
      else          m_wait  <= lat - 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check("cyc_in_ready", in_ready, (!m_valid && m_wait == 0));
      check("cyc_out_valid", out_valid, m_valid);
      if (m_valid) begin
        check("cyc_result", result, m_res);
        check("cyc_zero", zero, (m_res == 32'd0));
        check("cyc_illegal", illegal, m_ill);
      end
    end
  end

  task automatic run_op(input string name, input logic [1:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_r, input bit exp_ill, input int exp_lat,
                        input int stall, input bit poke);
    int waitc;
    int lat;
    waitc = 0;
    while (!in_ready && waitc < 100) begin
      @(posedge clk); #1;
      waitc++;
    end
    check({name, "_in_ready"}, in_ready, 1);
    aluop = op; funct3 = f3; funct7 = f7; op_a = a; op_b = b;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    op_a = $urandom; op_b = $urandom; funct3 = 3'($urandom); funct7 = 7'($urandom);
    if (poke) aluop = 2'b01;
    else      in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_result"}, result, exp_r);
    check({name, "_zero"}, zero, (exp_r == 32'd0));
    check({name, "_illegal"}, illegal, exp_ill);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check({name, "_stall_result"}, result, exp_r);
      check({name, "_stall_in_ready"}, in_ready, 0);
      check({name, "_stall_out_valid"}, out_valid, 1);
    end
    out_ready = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit seen;
    logic [31:0] mr;
    bit mi;
    int ml;
    logic [2:0] m_f3 [3];
    m_f3[0] = 3'd0; m_f3[1] = 3'd5; m_f3[2] = 3'd7;

    // Reset held together with a request: reset must win.
    reset = 1'b1; in_valid = 1'b1; in_valid0 = 1'b0; out_ready = 1'b0;
    aluop = 2'b10; funct3 = 3'd0; funct7 = 7'h00; op_a = 32'd5; op_b = 32'd6;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0; in_valid = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_result", result, 0);
    check("rst_zero", zero, 1);
    check("rst_illegal", illegal, 0);
    @(posedge clk); #1;
    check("rst_no_accept", out_valid, 0);

    run_op("add_ovf", 2'b10, 3'd0, 7'h00, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 0, 1, 0, 0);
    run_op("sub_br",  2'b01, 3'd3, 7'h7F, 32'h1234, 32'h1234, 32'd0, 0, 1, 0, 0);
    run_op("slt",     2'b10, 3'd2, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd1, 0, 1, 0, 0);
    run_op("sltu",    2'b10, 3'd3, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 1, 0, 0);
    run_op("sra",     2'b10, 3'd5, 7'h20, 32'h8000_0000, 32'd4, 32'hF800_0000, 0, 1, 0, 0);
    run_op("srai",    2'b00, 3'd5, 7'h20, 32'h8000_0000, 32'h404, 32'hF800_0000, 0, 1, 0, 0);
    run_op("srli",    2'b00, 3'd5, 7'h00, 32'h8000_0000, 32'd4, 32'h0800_0000, 0, 1, 0, 0);
    run_op("sll_msk", 2'b10, 3'd1, 7'h00, 32'd1, 32'h21, 32'd2, 0, 1, 0, 0);
    run_op("sub_r",   2'b10, 3'd0, 7'h20, 32'd5, 32'd7, 32'hFFFF_FFFE, 0, 1, 0, 0);
    run_op("ori",     2'b00, 3'd6, 7'h00, 32'hF0F0, 32'h0F0F, 32'hFFFF, 0, 1, 0, 0);
    run_op("andi",    2'b00, 3'd7, 7'h00, 32'hF0F0, 32'hFF, 32'hF0, 0, 1, 0, 0);
    run_op("xor_stl", 2'b00, 3'd4, 7'h00, 32'hF0F0, 32'hFF, 32'hF00F, 0, 1, 5, 0);
    run_op("mul",     2'b10, 3'd0, 7'h01, 32'hFFFF, 32'h1_0001, 32'hFFFF_FFFF, 0, 33, 0, 1);
    run_op("divu",    2'b10, 3'd5, 7'h01, 32'd100, 32'd7, 32'd14, 0, 33, 0, 0);
    run_op("remu",    2'b10, 3'd7, 7'h01, 32'd100, 32'd7, 32'd2, 0, 33, 2, 0);
    run_op("divu_z",  2'b10, 3'd5, 7'h01, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 0, 33, 0, 0);
    run_op("remu_z",  2'b10, 3'd7, 7'h01, 32'd5, 32'd0, 32'd5, 0, 33, 0, 0);
    run_op("ill_r20", 2'b10, 3'd1, 7'h20, 32'd9, 32'd3, 32'd0, 1, 1, 0, 0);
    run_op("ill_op3", 2'b11, 3'd0, 7'h00, 32'd9, 32'd3, 32'd0, 1, 1, 0, 0);
    run_op("ill_mf3", 2'b10, 3'd1, 7'h01, 32'd9, 32'd3, 32'd0, 1, 1, 0, 0);
    run_op("ill_f7",  2'b10, 3'd0, 7'h02, 32'd9, 32'd3, 32'd0, 1, 1, 0, 0);

    // ENABLE_M = 0 instance: M encodings decode as illegal on the single-cycle path.
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      aluop = 2'b10; funct7 = 7'h01; funct3 = m_f3[k]; op_a = 32'hFFFF; op_b = 32'h1_0001;
      model_op(aluop, funct3, funct7, op_a, op_b, 1'b0, mr, mi, ml);
      check("nom_in_ready", in_ready0, 1);
      in_valid0 = 1'b1;
      @(posedge clk); #1;
      in_valid0 = 1'b0;
      check("nom_out_valid", out_valid0, 1);
      check("nom_illegal", illegal0, 1);
      check("nom_result", result0, 0);
      check("nom_zero", zero0, 1);
      check("nom_model", {mi, mr}, {1'b1, 32'd0});
    end
    @(posedge clk); #1;
    aluop = 2'b10; funct7 = 7'h00; funct3 = 3'd0; op_a = 32'd40; op_b = 32'd2;
    in_valid0 = 1'b1;
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    check("nom_add_result", result0, 42);
    check("nom_add_illegal", illegal0, 0);

    // Reset in the middle of a division: the result must never appear.
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("abort_pre_ready", in_ready, 1);
    aluop = 2'b10; funct7 = 7'h01; funct3 = 3'd5; op_a = 32'd100; op_b = 32'd7;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    check("abort_mid_busy", in_ready, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_result", result, 0);
    check("abort_zero", zero, 1);
    check("abort_illegal", illegal, 0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("abort_never_valid", seen, 0);

    run_op("post_add", 2'b00, 3'd0, 7'h00, 32'd1, 32'hFFFF_FFFF, 32'd0, 0, 1, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter XLEN, default 32, operand/result width in bits (8..64).
REQ-002 Parameter ENABLE_M, default 1, 1 = iterative MUL/DIVU/REMU present, 0 = those encodings are illegal.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operation request valid.
REQ-006 in_ready  output  1  unit can accept a request this cycle.
REQ-007 aluop  input  2  00 I-type, 01 branch SUB, 10 R-type, 11 reserved.
REQ-008 funct3  input  3  instruction funct3.
REQ-009 funct7  input  7  instruction funct7; for I-type only bit 5 is used (SRAI).
REQ-010 op_a  input  XLEN  operand A (rs1).
REQ-011 op_b  input  XLEN  operand B (rs2 or sign-extended immediate).
REQ-012 out_valid  output  1  result valid; held until accepted.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 result  output  XLEN  operation result.
REQ-015 zero  output  1  result == 0.
REQ-016 illegal  output  1  the operation held in result was an undecodable encoding.

Function
REQ-017 Request accepted on a cycle with in_valid && in_ready; aluop/funct*/op_a/op_b captured that cycle, no later dependence.
REQ-018 FSM states IDLE, ITER, DONE; in_ready = 1 only in IDLE.
REQ-019 IDLE -> DONE on accept of a single-cycle op; IDLE -> ITER on accept of MUL/DIVU/REMU; ITER -> DONE after exactly XLEN iteration cycles; DONE -> IDLE on out_ready.
REQ-020 out_valid = 1 exactly in DONE; result/zero/illegal stable while out_valid && !out_ready.
REQ-021 Latency: single-cycle op out_valid the cycle after accept; iterative op out_valid XLEN+1 cycles after accept.
REQ-022 aluop 00, funct3: 000 ADD, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND, 001 SLL, 101 SRL (funct7[5]=0) / SRA (funct7[5]=1).
REQ-023 aluop 01: SUB regardless of funct fields.
REQ-024 aluop 10, funct7 0000000: funct3 decoded as REQ-022 (000 ADD); funct7 0100000: 000 SUB, 101 SRA, others illegal.
REQ-025 aluop 10, funct7 0000001 with ENABLE_M=1: 000 MUL (low XLEN bits), 101 DIVU, 111 REMU; other funct3 illegal.
REQ-026 Any other funct7 with aluop 10, and all of aluop 11: illegal=1, result=0, single-cycle path.
REQ-027 Arithmetic modulo 2^XLEN; SLT/SLTU result is 0 or 1 zero-extended; shift amount = op_b[$clog2(XLEN)-1:0].
REQ-028 MUL: shift-add, one partial product bit per cycle; DIVU/REMU: restoring division, one quotient bit per cycle.
REQ-029 Divide by zero: DIVU result all ones, REMU result = op_a; still XLEN iteration cycles; illegal=0.
REQ-030 in_valid while not IDLE is ignored; no request queued.
REQ-031 Back-to-back: out_ready=1 in DONE allows accept in following cycle (IDLE), giving one single-cycle op per 2 cycles.

Reset
REQ-032 reset asserted: next state IDLE; out_valid=0, in_ready=1 from following cycle, result=0, zero=1, illegal=0, iteration counter=0.
REQ-033 reset during ITER or DONE aborts the operation; the result is discarded, never presented.
REQ-034 reset has priority over accept and out_ready in the same cycle.

Verification
REQ-035 XLEN=32: ADD op_a=0x7FFFFFFF op_b=1 aluop=10 -> next cycle out_valid, result 0x80000000, zero 0.
REQ-036 SUB aluop=01 op_a=op_b=0x1234 -> result 0, zero 1; SLT op_a=0xFFFFFFFF op_b=1 -> 1; SLTU same -> 0; SRA 0x80000000 by 4 -> 0xF8000000.
REQ-037 MUL 0xFFFF x 0x10001 -> out_valid exactly 33 cycles after accept, result 0xFFFFFFFF; in_valid during ITER ignored, in_ready 0.
REQ-038 DIVU 100/7 -> 14, REMU -> 2; DIVU x/0 -> 0xFFFFFFFF, REMU 5/0 -> 5; ENABLE_M=0 MUL -> illegal 1, result 0.
REQ-039 out_ready held 0 for 5 cycles in DONE -> result stable, in_ready 0; reset asserted mid-DIVU -> out_valid never asserts, in_ready 1 next cycle.
